// File: rtl/led_pkg.sv
// Constants shared by the LED output path: the PIO, this driver and the pin map.
package led_pkg;
    localparam int LED_WIDTH          = 10;
    localparam int LED_PWM_BITS       = 8;
    localparam int LED_PRESCALE       = 50;
    localparam int LED_BLINK_PERIODS  = 64;
endpackage

// File: rtl/led_tick_gen.sv
// Prescaler for the LED PWM: emits a one-cycle tick every PRESCALE clocks.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int PRESCALE = LED_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_pre_cnt;
    logic          w_tick;

    assign w_tick = (r_pre_cnt == LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_pwm_driver.sv
// Drives the board LEDs from the PIO pattern with global PWM brightness and per-LED
// blink; all inputs are shadowed at PWM period boundaries so writes never glitch.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int WIDTH         = LED_WIDTH,
    parameter int PRESCALE      = LED_PRESCALE,
    parameter int PWM_BITS      = LED_PWM_BITS,
    parameter int BLINK_PERIODS = LED_BLINK_PERIODS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    led_pattern,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blink_en,
    input  logic [WIDTH-1:0]    blink_mask,
    output logic [WIDTH-1:0]    led_out,
    output logic                period_start
);
    localparam int            BW     = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BW-1:0] BLAST  = BW'(BLINK_PERIODS - 1);

    logic                r_first;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [WIDTH-1:0]    r_sh_pattern;
    logic [WIDTH-1:0]    r_sh_mask;
    logic [PWM_BITS-1:0] r_sh_duty;
    logic                r_sh_blink;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink_phase;
    logic [WIDTH-1:0]    r_led_out;
    logic                r_period_start;

    logic                w_tick;
    logic                w_true_boundary;
    logic                w_boundary;
    logic                w_on_pwm;
    logic                w_blank;
    logic [WIDTH-1:0]    w_led_next;

    led_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // The forced boundary right after reset lets the LEDs respond without a full period.
    assign w_true_boundary = w_tick & (r_pwm_cnt == '1);
    assign w_boundary      = r_first | w_true_boundary;
    assign w_on_pwm        = (r_sh_duty == '1) | (r_pwm_cnt < r_sh_duty);
    assign w_blank         = r_sh_blink & r_blink_phase;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_led
            assign w_led_next[gi] = r_sh_pattern[gi] & w_on_pwm & ~(w_blank & r_sh_mask[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first        <= 1'b1;
            r_pwm_cnt      <= '0;
            r_sh_pattern   <= '0;
            r_sh_mask      <= '0;
            r_sh_duty      <= '0;
            r_sh_blink     <= 1'b0;
            r_period_start <= 1'b0;
            r_led_out      <= '0;
        end else begin
            r_first        <= 1'b0;
            r_period_start <= w_boundary;
            r_led_out      <= w_led_next;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            if (w_boundary) begin
                r_sh_pattern <= led_pattern;
                r_sh_mask    <= blink_mask;
                r_sh_duty    <= duty;
                r_sh_blink   <= blink_en;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!r_sh_blink) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_true_boundary) begin
            if (r_blink_cnt == BLAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign led_out      = r_led_out;
    assign period_start = r_period_start;
endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with a time-indexed reference model.
module tb_led_pwm_driver;
    localparam int W  = 10;
    localparam int PS = 2;
    localparam int PB = 3;
    localparam int BP = 2;
    localparam int PWM_MAX = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  led_pattern = '0;
    logic [PB-1:0] duty = '0;
    logic          blink_en = 1'b0;
    logic [W-1:0]  blink_mask = '0;
    logic [W-1:0]  led_out;
    logic          period_start;

    int errs = 0;
    int chks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .WIDTH         (W),
        .PRESCALE      (PS),
        .PWM_BITS      (PB),
        .BLINK_PERIODS (BP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .led_pattern  (led_pattern),
        .duty         (duty),
        .blink_en     (blink_en),
        .blink_mask   (blink_mask),
        .led_out      (led_out),
        .period_start (period_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time is the clock count since reset release; the PWM position
    // and boundaries follow from that count, blink phase from boundaries seen while enabled.
    int       m_n;
    bit       m_first;
    logic [W-1:0] m_pat, m_mask, exp_led;
    int       m_duty;
    bit       m_blink;
    int       m_periods;
    bit       exp_ps;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0; m_first = 1; m_pat = '0; m_mask = '0; m_duty = 0;
            m_blink = 0; m_periods = 0; exp_led = '0; exp_ps = 0;
        end else begin
            int  pwm;
            bit  tick, true_b, bnd, lit, dark;
            pwm    = (m_n / PS) % (PWM_MAX + 1);
            tick   = (m_n % PS) == PS - 1;
            true_b = tick && (pwm == PWM_MAX);
            bnd    = m_first || true_b;
            lit    = (m_duty == PWM_MAX) || (pwm < m_duty);
            dark   = m_blink && (((m_periods / BP) % 2) == 1);
            exp_led = lit ? (m_pat & ~(dark ? m_mask : '0)) : '0;
            exp_ps  = bnd;
            if (!m_blink) m_periods = 0;
            else if (true_b) m_periods = m_periods + 1;
            if (bnd) begin
                m_pat = led_pattern; m_mask = blink_mask;
                m_duty = int'(duty); m_blink = blink_en;
            end
            m_first = 0;
            m_n = m_n + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_led_out", 32'(led_out), 32'(exp_led));
            check("model_period_start", 32'(period_start), 32'(exp_ps));
        end
    end

    task automatic wait_ps(input string tag);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = period_start;
        end
        check({tag, "_wait_period_start"}, 32'(got), 32'd1);
    endtask

    task automatic release_checks(input string tag);
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_ps_clk1"}, 32'(period_start), 32'd1);
        check({tag, "_led_clk1"}, 32'(led_out), 32'h0);
        @(negedge clk);
        check({tag, "_led_clk2"}, 32'(led_out), 32'h3FF);
        check({tag, "_ps_clk2"}, 32'(period_start), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check({tag, "_steady"}, 32'(led_out), 32'h3FF);
        end
        $display("%s: release sequence done", tag);
    endtask

    initial begin
        int ones, ones_b, hi;
        led_pattern = 10'h3FF; duty = 3'd7;
        cmp_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_reset_led", 32'(led_out), 32'h0);
            check("t1_reset_ps", 32'(period_start), 32'd0);
        end
        release_checks("t1");

        led_pattern = 10'h001; duty = 3'd3;
        wait_ps("t2");
        ones = 0; hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ones += int'(led_out[0]);
            hi   |= int'(led_out[W-1:1]);
        end
        check("t2_bit0_on_cycles", 32'(ones), 32'd6);
        check("t2_upper_bits", 32'(hi), 32'd0);
        $display("t2: duty 3 bit0 on %0d of 16", ones);

        led_pattern = 10'h3FF; duty = 3'd0;
        wait_ps("t3");
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ones += int'(|led_out);
        end
        check("t3_duty0_dark", 32'(ones), 32'd0);
        $display("t3: duty 0 lit cycles %0d", ones);

        led_pattern = 10'h001; duty = 3'd7;
        wait_ps("t4_setup");
        repeat (8) @(negedge clk);
        led_pattern = 10'h002;
        begin
            bit got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                check("t4_hold_old", 32'(led_out), 32'h001);
                got = period_start;
            end
            check("t4_wait_period_start", 32'(got), 32'd1);
        end
        @(negedge clk);
        check("t4_new_pattern", 32'(led_out), 32'h002);
        $display("t4: mid-period pattern change deferred");

        blink_en = 1'b1; blink_mask = 10'h001; led_pattern = 10'h003; duty = 3'd7;
        wait_ps("t5");
        ones = 0; ones_b = 0; hi = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i < 32) ones += int'(led_out[0]);
            else        ones_b += int'(led_out[0]);
            hi += int'(led_out[1]);
        end
        check("t5_bit0_first_half", 32'(ones), 32'd32);
        check("t5_bit0_second_half", 32'(ones_b), 32'd0);
        check("t5_bit1_steady", 32'(hi), 32'd64);
        $display("t5: blink on %0d off-phase on %0d bit1 %0d", ones, ones_b, hi);

        blink_en = 1'b0; blink_mask = '0; led_pattern = 10'h3FF; duty = 3'd7;
        wait_ps("t6");
        repeat (10) @(negedge clk);
        check("t6_lit_before_reset", 32'(led_out), 32'h3FF);
        #2 reset = 1'b1;
        #1;
        check("t6_async_led", 32'(led_out), 32'h0);
        check("t6_async_ps", 32'(period_start), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_reset_led", 32'(led_out), 32'h0);
        end
        release_checks("t6");

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
